// File: rtl/mem_pkg.sv
// Shared types, defaults and range-check helper for the memory copy engine.
`timescale 1ns/1ps
package mem_pkg;

    localparam int DEF_MEM_SIZE = 256;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_LEN_W    = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        FIN   = 2'd3
    } copy_state_t;

    // 33-bit sum so a base near 2^32 cannot wrap back into range.
    function automatic logic in_range(input logic [31:0] base,
                                      input logic [31:0] len,
                                      input logic [31:0] size);
        logic [32:0] end_excl;
        end_excl = {1'b0, base} + {1'b0, len};
        return end_excl <= {1'b0, size};
    endfunction

endpackage

// File: rtl/mem_copy_engine.sv
// Block copy initiator driving a single-port word memory (comb read, sync write).
// Optional running checksum of the words read: define MEM_COPY_CHECKSUM_EN.
`timescale 1ns/1ps
module mem_copy_engine
    import mem_pkg::*;
#(
    parameter int MEM_SIZE = mem_pkg::DEF_MEM_SIZE,
    parameter int DATA_W   = mem_pkg::DEF_DATA_W,
    parameter int LEN_W    = mem_pkg::DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       src_addr,
    input  logic [31:0]       dst_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [31:0]       mem_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    copy_state_t       state, state_next;
    logic [31:0]       src_q, dst_q;
    logic [LEN_W-1:0]  len_q, idx_q;
    logic [DATA_W-1:0] data_q;
    logic              err_q;
    logic              accept;
    logic              range_ok;
    logic              last_word;
    logic [31:0]       idx_ext;

    assign idx_ext   = {{(32-LEN_W){1'b0}}, idx_q};
    assign last_word = (idx_q == (len_q - LEN_W'(1)));
    assign range_ok  = in_range(src_addr, {{(32-LEN_W){1'b0}}, length}, 32'(MEM_SIZE)) &&
                       in_range(dst_addr, {{(32-LEN_W){1'b0}}, length}, 32'(MEM_SIZE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next       = state;
        accept           = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        error            = 1'b0;
        mem_address      = '0;
        mem_write_enable = 1'b0;
        mem_write_data   = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept = 1'b1;
                    if (length == '0 || !range_ok) state_next = FIN;
                    else                           state_next = READ;
                end
            end
            READ: begin
                busy        = 1'b1;
                mem_address = src_q + idx_ext;
                state_next  = WRITE;
            end
            WRITE: begin
                busy             = 1'b1;
                mem_address      = dst_q + idx_ext;
                mem_write_enable = 1'b1;
                mem_write_data   = data_q;
                state_next       = last_word ? FIN : READ;
            end
            FIN: begin
                done       = 1'b1;
                error      = err_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            dst_q  <= '0;
            len_q  <= '0;
            idx_q  <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            len_q <= length;
            idx_q <= '0;
            err_q <= (length != '0) && !range_ok;
        end else if (state == READ) begin
            data_q <= mem_read_data;
        end else if (state == WRITE) begin
            idx_q <= idx_q + LEN_W'(1);
        end
    end

`ifdef MEM_COPY_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                checksum <= '0;
        else if (accept)        checksum <= '0;
        else if (state == READ) checksum <= checksum + mem_read_data;
    end
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed self-checking bench for mem_copy_engine with a behavioural word memory.
`timescale 1ns/1ps
module tb_mem_copy_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] src_addr, dst_addr;
    logic [8:0]  length;
    logic        busy, done, error;
    logic [31:0] mem_address;
    logic        mem_write_enable;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    logic [31:0] mem [256];
    logic        pre_we;
    logic [7:0]  pre_addr;
    logic [31:0] pre_data;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_copy_engine dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .src_addr         (src_addr),
        .dst_addr         (dst_addr),
        .length           (length),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mem_address      (mem_address),
        .mem_write_enable (mem_write_enable),
        .mem_write_data   (mem_write_data),
        .mem_read_data    (mem_read_data)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    assign mem_read_data = mem[mem_address[7:0]];

    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;
        else if (pre_we)      mem[pre_addr] <= pre_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we   = 1'b1;
        pre_addr = a;
        pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    // Starts a request and watches a fixed window; cyc is the cycle of the
    // first done pulse after the accepting edge, or 0 when no pulse occurs.
    task automatic run(input logic [31:0] s, input logic [31:0] d, input logic [8:0] l,
                       input bit glitch, output int cyc, output logic er,
                       output int busy_n, output int we_n, output int done_n);
        int budget;
        budget = 2 * int'(l) + 5;
        cyc = 0; er = 1'bx; busy_n = 0; we_n = 0; done_n = 0;
        @(negedge clk);
        src_addr = s; dst_addr = d; length = l; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int c = 1; c <= budget; c++) begin
            if (busy) busy_n++;
            if (mem_write_enable) we_n++;
            if (done) begin
                done_n++;
                if (cyc == 0) begin
                    cyc = c;
                    er  = error;
                end
            end
            if (glitch && c == 3) begin
                start = 1'b1; src_addr = 32'd0; dst_addr = 32'd50; length = 9'd2;
            end
            if (glitch && c == 4) start = 1'b0;
            @(posedge clk);
            #1;
        end
    endtask

    int   cyc, busy_n, we_n, done_n;
    logic er;

    initial begin
        rst = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 | 32'(i);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_addr", mem_address, 32'd0);
        check("rst_we", 32'(mem_write_enable), 32'd0);
        check("rst_wdata", mem_write_data, 32'd0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("rst_checksum", checksum, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // basic copy
        for (int i = 0; i < 4; i++) preload(8'(10 + i), 32'(i + 1));
        run(32'd10, 32'd100, 9'd4, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("basic_done_cycle", 32'(cyc), 32'd9);
        check("basic_error", 32'(er), 32'd0);
        check("basic_busy_cycles", 32'(busy_n), 32'd8);
        check("basic_we_cycles", 32'(we_n), 32'd4);
        check("basic_done_pulses", 32'(done_n), 32'd1);
        for (int i = 0; i < 4; i++) check("basic_mem", mem[100 + i], 32'(i + 1));
        check("basic_idle_addr", mem_address, 32'd0);

        // zero length
        run(32'd5, 32'd6, 9'd0, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("zero_done_cycle", 32'(cyc), 32'd1);
        check("zero_error", 32'(er), 32'd0);
        check("zero_we_cycles", 32'(we_n), 32'd0);
        check("zero_busy_cycles", 32'(busy_n), 32'd0);

        // last legal source window 252..255
        for (int i = 0; i < 4; i++) preload(8'(252 + i), 32'h0000_0011 * 32'(i + 1));
        run(32'd252, 32'd0, 9'd4, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("edge_done_cycle", 32'(cyc), 32'd9);
        check("edge_error", 32'(er), 32'd0);
        for (int i = 0; i < 4; i++) check("edge_mem", mem[i], 32'h0000_0011 * 32'(i + 1));

        // out of range requests
        run(32'd253, 32'd30, 9'd4, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("rej_src_done_cycle", 32'(cyc), 32'd1);
        check("rej_src_error", 32'(er), 32'd1);
        check("rej_src_we_cycles", 32'(we_n), 32'd0);
        check("rej_src_mem", mem[30], 32'hDEAD_001E);
        run(32'd0, 32'd253, 9'd4, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("rej_dst_error", 32'(er), 32'd1);
        check("rej_dst_mem", mem[253], 32'h0000_0022);
        run(32'hFFFF_FFFF, 32'd0, 9'd2, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("rej_wrap_error", 32'(er), 32'd1);
        check("rej_wrap_done_cycle", 32'(cyc), 32'd1);

        // overlapping forward smear
        preload(8'd0, 32'hA); preload(8'd1, 32'hB); preload(8'd2, 32'hC); preload(8'd3, 32'hD);
        run(32'd0, 32'd1, 9'd3, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("ovl_done_cycle", 32'(cyc), 32'd7);
        for (int i = 0; i < 4; i++) check("ovl_mem", mem[i], 32'hA);

        // reset during the third WRITE of an 8-word copy
        for (int i = 0; i < 8; i++) preload(8'(20 + i), 32'h100 + 32'(i));
        @(negedge clk);
        src_addr = 32'd20; dst_addr = 32'd150; length = 9'd8; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rstmid_pre_we", 32'(mem_write_enable), 32'd1);
        check("rstmid_pre_addr", mem_address, 32'd152);
        rst = 1'b1;
        #1;
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_we", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_mem0", mem[150], 32'h100);
        check("rstmid_mem1", mem[151], 32'h101);
        check("rstmid_mem2", mem[152], 32'hDEAD_0098);
        run(32'd20, 32'd160, 9'd2, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("post_rst_done_cycle", 32'(cyc), 32'd5);
        check("post_rst_mem", mem[161], 32'h101);

        // start pulsed mid-transfer must be ignored
        run(32'd10, 32'd200, 9'd4, 1'b1, cyc, er, busy_n, we_n, done_n);
        check("ign_done_cycle", 32'(cyc), 32'd9);
        check("ign_done_pulses", 32'(done_n), 32'd1);
        check("ign_we_cycles", 32'(we_n), 32'd4);
        check("ign_mem_last", mem[203], 32'd4);
        check("ign_mem_other", mem[50], 32'hDEAD_0032);
        check("ign_idle_busy", 32'(busy), 32'd0);

`ifdef MEM_COPY_CHECKSUM_EN
        preload(8'd0, 32'hFFFF_FFFF); preload(8'd1, 32'h2); preload(8'd2, 32'h5);
        run(32'd0, 32'd40, 9'd3, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("csum_value", checksum, 32'h0000_0006);
        run(32'd253, 32'd0, 9'd4, 1'b0, cyc, er, busy_n, we_n, done_n);
        check("csum_rejected", checksum, 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
